// File: rtl/seq_multiplier_nbit.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in WIDTH+1 cycles,
// unsigned or two's-complement per operation, with a start/busy/done handshake.
module seq_multiplier_nbit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [2*WIDTH-1:0]   w_addend;

  // The most-negative operand negates to itself, which reads correctly as the unsigned magnitude.
  assign w_magA   = (is_signed & a[WIDTH-1]) ? -a : a;
  assign w_magB   = (is_signed & b[WIDTH-1]) ? -b : b;
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_count == LAST) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Multiplicand is pre-shifted each iteration, so it always sits at weight 2^count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_magA};
            r_mplier <= w_magB;
            r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_acc    <= r_acc + w_addend;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + ONE;
        end
        FINISH: begin
          r_product <= r_neg ? -r_acc : r_acc;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier_nbit.sv
// Bench for seq_multiplier_nbit: directed and random WIDTH=8 operations plus an
// exhaustive back-to-back WIDTH=4 sweep, all checked against an arithmetic model.
module tb_seq_multiplier_nbit;

  logic        clk;
  logic        rst;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start4, sgn4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  product4;

  int          checks;
  int          failures;
  logic [15:0] lastProd;
  int          lat, latBad4, dones4, busyBad4, rstDones;
  logic [7:0]  ra, rb;
  bit          rs;

  seq_multiplier_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_multiplier_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] refProduct(input int w, input logic [31:0] x,
                                             input logic [31:0] y, input bit sgn);
    longint sx, sy, p, m;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (sgn && sx >= (longint'(1) << (w - 1))) sx = sx - (longint'(1) << w);
    if (sgn && sy >= (longint'(1) << (w - 1))) sy = sy - (longint'(1) << w);
    p = sx * sy;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one WIDTH=8 request and watches 20 edges; optionally pokes a second
  // start (a=b=7) just before edge injectAt to confirm it is dropped.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input bit sgn,
                               input int injectAt, input logic [15:0] prevProd,
                               output int doneEdge, output int doneCnt,
                               output int busyCnt, output int holdBad);
    start8 = 1'b1; a8 = ia; b8 = ib; sgn8 = sgn;
    @(posedge clk); #1;
    busyCnt = busy8 ? 1 : 0;
    doneCnt = 0; doneEdge = -1; holdBad = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == injectAt) begin
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd7; sgn8 = 1'b0;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      end
      @(posedge clk); #1;
      if (busy8) busyCnt++;
      if (done8) begin
        doneCnt++;
        if (doneEdge < 0) doneEdge = e;
      end
      if (doneEdge < 0 && product8 !== prevProd) holdBad++;
    end
    start8 = 1'b0;
  endtask

  task automatic doOp8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input bit sgn, input int injectAt, input logic [15:0] expProd);
    int de, dc, bc, hb;
    applyStimulus(ia, ib, sgn, injectAt, lastProd, de, dc, bc, hb);
    checkOutput({tag, ".doneEdge"}, 64'(de), 64'd9);
    checkOutput({tag, ".doneCount"}, 64'(dc), 64'd1);
    checkOutput({tag, ".busyCycles"}, 64'(bc), 64'd9);
    checkOutput({tag, ".holdPrev"}, 64'(hb), 64'd0);
    checkOutput({tag, ".product"}, 64'(product8), 64'(expProd));
    lastProd = expProd;
  endtask

  initial begin
    checks = 0; failures = 0; lastProd = 16'd0;
    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = 4'd0; b4 = 4'd0;

    #12;
    checkOutput("reset.product8", 64'(product8), 64'd0);
    checkOutput("reset.done8", 64'(done8), 64'd0);
    checkOutput("reset.busy8", 64'(busy8), 64'd0);
    checkOutput("reset.product4", 64'(product4), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed WIDTH=8 operations");
    doOp8("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 0, 16'hFE01);
    doOp8("s_80_80", 8'h80, 8'h80, 1'b1, 0, 16'h4000);
    doOp8("s_fd_05", 8'hFD, 8'h05, 1'b1, 0, 16'hFFF1);
    doOp8("s_00_80", 8'h00, 8'h80, 1'b1, 0, 16'h0000);
    doOp8("busyIgnore", 8'd3, 8'd4, 1'b0, 3, 16'd12);

    $display("[TB] random WIDTH=8 operations");
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      doOp8($sformatf("rand%0d", i), ra, rb, rs, 0, 16'(refProduct(8, 32'(ra), 32'(rb), rs)));
    end

    $display("[TB] reset during an operation");
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd10; sgn8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midReset.busy", 64'(busy8), 64'd0);
    checkOutput("midReset.done", 64'(done8), 64'd0);
    checkOutput("midReset.product", 64'(product8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    lastProd = 16'd0;
    rstDones = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done8) rstDones++;
    end
    checkOutput("midReset.noDone", 64'(rstDones), 64'd0);
    checkOutput("midReset.productHeld", 64'(product8), 64'd0);
    doOp8("afterReset", 8'd2, 8'd3, 1'b0, 0, 16'd6);
    doOp8("hold", 8'd9, 8'd9, 1'b0, 0, 16'd81);

    $display("[TB] exhaustive WIDTH=4 back-to-back");
    latBad4 = 0; dones4 = 0; busyBad4 = 0;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a4 = 4'(x); b4 = 4'(y); sgn4 = s[0]; start4 = 1'b1;
          @(posedge clk); #1;
          lat = 0;
          for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (done4) begin
              lat = e;
              break;
            end
          end
          if (lat == 5) dones4++;
          else latBad4++;
          if (busy4) busyBad4++;
          checkOutput($sformatf("w4.s%0d.%0d*%0d", s, x, y), 64'(product4),
                      refProduct(4, 32'(x), 32'(y), s[0]));
        end
      end
    end
    start4 = 1'b0;
    checkOutput("w4.latencyBad", 64'(latBad4), 64'd0);
    checkOutput("w4.doneCount", 64'(dones4), 64'd512);
    checkOutput("w4.busyInDone", 64'(busyBad4), 64'd0);
    @(posedge clk); #1;
    checkOutput("w4.idleAfter", 64'(busy4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
